// File: rtl/ysyx_23060124_wb_arbiter_pkg.sv
// Shared widths and writeback request type for the GPR writeback arbiter.
package ysyx_23060124_wb_arbiter_pkg;

  localparam int XLEN   = 32;
  localparam int NR_REG = 16;
  localparam int AW     = 4;

  // One writeback request as it travels from a requester into the output register.
  typedef struct packed {
    logic            wen;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wdata;
  } wb_req_t;

  // Which requester won the most recent grant; the other one wins the next tie.
  typedef enum logic {
    SIDE_EXU = 1'b0,
    SIDE_LSU = 1'b1
  } side_e;

endpackage

// File: rtl/ysyx_23060124_wb_arbiter_if.sv
// Bundle of issue, hazard-check, EXU/LSU writeback and register-file signals.
// The slave modport is the arbiter; the master modport is everything around it.
interface ysyx_23060124_wb_arbiter_if #(
  parameter int XLEN = ysyx_23060124_wb_arbiter_pkg::XLEN,
  parameter int AW   = ysyx_23060124_wb_arbiter_pkg::AW
) ();

  logic            i_iss_valid;
  logic            i_iss_wen;
  logic [AW-1:0]   i_iss_rd;
  logic            o_iss_ready;
  logic [AW-1:0]   i_chk_rs1;
  logic [AW-1:0]   i_chk_rs2;
  logic            o_hazard;

  logic            i_exu_valid;
  logic            o_exu_ready;
  logic            i_exu_wen;
  logic [AW-1:0]   i_exu_rd;
  logic [XLEN-1:0] i_exu_wdata;

  logic            i_lsu_valid;
  logic            o_lsu_ready;
  logic [AW-1:0]   i_lsu_rd;
  logic [XLEN-1:0] i_lsu_wdata;

  logic            o_rf_wen;
  logic [AW-1:0]   o_rf_waddr;
  logic [XLEN-1:0] o_rf_wdata;
  logic            o_busy;

  modport master (
    output i_iss_valid, i_iss_wen, i_iss_rd, i_chk_rs1, i_chk_rs2,
    output i_exu_valid, i_exu_wen, i_exu_rd, i_exu_wdata,
    output i_lsu_valid, i_lsu_rd, i_lsu_wdata,
    input  o_iss_ready, o_hazard, o_exu_ready, o_lsu_ready,
    input  o_rf_wen, o_rf_waddr, o_rf_wdata, o_busy
  );

  modport slave (
    input  i_iss_valid, i_iss_wen, i_iss_rd, i_chk_rs1, i_chk_rs2,
    input  i_exu_valid, i_exu_wen, i_exu_rd, i_exu_wdata,
    input  i_lsu_valid, i_lsu_rd, i_lsu_wdata,
    output o_iss_ready, o_hazard, o_exu_ready, o_lsu_ready,
    output o_rf_wen, o_rf_waddr, o_rf_wdata, o_busy
  );

endinterface

// File: rtl/ysyx_23060124_sb_cnt.sv
// One scoreboard entry: 2-bit saturating count of in-flight writes to a register.
module ysyx_23060124_sb_cnt (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [1:0] o_cnt
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  // A simultaneous issue and commit cancel out; otherwise step once, clamped to 0..3.
  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && !i_dec && cnt_q != 2'd3) begin
      cnt_d = cnt_q + 2'd1;
    end else if (i_dec && !i_inc && cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/ysyx_23060124_wb_arbiter.sv
// Round-robin arbiter sharing the GPR write port between EXU and LSU, plus a
// per-register scoreboard that tells the IDU when a source operand is still in flight.
module ysyx_23060124_wb_arbiter #(
  parameter int XLEN   = ysyx_23060124_wb_arbiter_pkg::XLEN,
  parameter int NR_REG = ysyx_23060124_wb_arbiter_pkg::NR_REG,
  parameter int AW     = ysyx_23060124_wb_arbiter_pkg::AW
) (
  input logic                        clk,
  input logic                        i_rst_n,
  ysyx_23060124_wb_arbiter_if.slave  bus
);
  import ysyx_23060124_wb_arbiter_pkg::*;

  logic [1:0]        cnt [NR_REG];
  logic [NR_REG-1:1] incVec;
  logic [NR_REG-1:1] decVec;
  logic              issTracked;
  logic              issReady;
  logic              anyBusy;

  logic              grantExu;
  logic              grantLsu;
  wb_req_t           grantReq;
  side_e             lastSide_q;
  side_e             lastSide_d;

  logic              rfWen_q;
  logic              rfWen_d;
  logic [AW-1:0]     rfWaddr_q;
  logic [AW-1:0]     rfWaddr_d;
  logic [XLEN-1:0]   rfWdata_q;
  logic [XLEN-1:0]   rfWdata_d;

  // x0 is hardwired, so it never has a pending write.
  assign cnt[0] = 2'd0;

  for (genvar g = 1; g < NR_REG; g++) begin : gen_sb
    ysyx_23060124_sb_cnt u_cnt (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_inc   (incVec[g]),
      .i_dec   (decVec[g]),
      .o_cnt   (cnt[g])
    );
  end

  // Issue side: refuse an issue whose destination counter is already full, and
  // route issue increments and commit decrements to the matching counters.
  always_comb begin
    issTracked = bus.i_iss_wen && (bus.i_iss_rd != '0);
    issReady   = !(issTracked && cnt[bus.i_iss_rd] == 2'd3);
    incVec     = '0;
    decVec     = '0;
    for (int i = 1; i < NR_REG; i++) begin
      incVec[i] = bus.i_iss_valid && issReady && issTracked && (bus.i_iss_rd == AW'(i));
      decVec[i] = rfWen_q && (rfWaddr_q == AW'(i));
    end
  end

  // Operand hazard and overall busy status, straight from the counters.
  always_comb begin
    anyBusy = 1'b0;
    for (int i = 1; i < NR_REG; i++) begin
      anyBusy = anyBusy || (cnt[i] != 2'd0);
    end
  end

  assign bus.o_iss_ready = issReady;
  assign bus.o_busy      = anyBusy;
  assign bus.o_hazard    = ((bus.i_chk_rs1 != '0) && (cnt[bus.i_chk_rs1] != 2'd0)) ||
                           ((bus.i_chk_rs2 != '0) && (cnt[bus.i_chk_rs2] != 2'd0));

  // Round-robin grant: a lone requester always wins, a tie goes to the side that
  // did not win last; the winning request is selected for the output register.
  always_comb begin
    grantExu   = bus.i_exu_valid && (!bus.i_lsu_valid || lastSide_q == SIDE_LSU);
    grantLsu   = bus.i_lsu_valid && (!bus.i_exu_valid || lastSide_q == SIDE_EXU);
    lastSide_d = lastSide_q;
    grantReq   = '0;
    if (grantExu) begin
      lastSide_d = SIDE_EXU;
      grantReq   = '{wen: bus.i_exu_wen, rd: bus.i_exu_rd, wdata: bus.i_exu_wdata};
    end else if (grantLsu) begin
      lastSide_d = SIDE_LSU;
      grantReq   = '{wen: 1'b1, rd: bus.i_lsu_rd, wdata: bus.i_lsu_wdata};
    end
    rfWen_d   = (grantExu || grantLsu) && grantReq.wen && (grantReq.rd != '0);
    rfWaddr_d = (grantExu || grantLsu) ? grantReq.rd    : rfWaddr_q;
    rfWdata_d = (grantExu || grantLsu) ? grantReq.wdata : rfWdata_q;
  end

  assign bus.o_exu_ready = grantExu;
  assign bus.o_lsu_ready = grantLsu;

  // Output register feeding the register file, plus the round-robin pointer.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rfWen_q    <= 1'b0;
      rfWaddr_q  <= '0;
      rfWdata_q  <= '0;
      lastSide_q <= SIDE_EXU;
    end else begin
      rfWen_q    <= rfWen_d;
      rfWaddr_q  <= rfWaddr_d;
      rfWdata_q  <= rfWdata_d;
      lastSide_q <= lastSide_d;
    end
  end

  assign bus.o_rf_wen   = rfWen_q;
  assign bus.o_rf_waddr = rfWaddr_q;
  assign bus.o_rf_wdata = rfWdata_q;

endmodule

// File: tb/tb_ysyx_23060124_wb_arbiter.sv
// Bench for the writeback arbiter: directed scenarios with literal expectations,
// then random traffic, all cross-checked every cycle against a behavioural model.
module tb_ysyx_23060124_wb_arbiter;

  localparam int XLEN   = 32;
  localparam int NR_REG = 16;
  localparam int AW     = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ysyx_23060124_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

  ysyx_23060124_wb_arbiter #(.XLEN(XLEN), .NR_REG(NR_REG), .AW(AW)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Behavioural model: pending-write counts per register, who won last, and the
  // write the register file should be seeing this cycle.
  int              mCnt [NR_REG];
  bit              mLastLsu;
  bit              mWen;
  logic [AW-1:0]   mAddr;
  logic [XLEN-1:0] mData;

  // 0 = nobody, 1 = EXU, 2 = LSU.
  function automatic int pickGrant();
    if (bus.i_exu_valid && bus.i_lsu_valid) return mLastLsu ? 1 : 2;
    if (bus.i_exu_valid) return 1;
    if (bus.i_lsu_valid) return 2;
    return 0;
  endfunction

  function automatic bit expIssReady();
    return !(bus.i_iss_wen && bus.i_iss_rd != 0 && mCnt[bus.i_iss_rd] == 3);
  endfunction

  function automatic bit expHazard();
    return (bus.i_chk_rs1 != 0 && mCnt[bus.i_chk_rs1] != 0) ||
           (bus.i_chk_rs2 != 0 && mCnt[bus.i_chk_rs2] != 0);
  endfunction

  function automatic bit expBusy();
    for (int i = 0; i < NR_REG; i++) if (mCnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model at each clock edge; reset clears it at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_REG; i++) mCnt[i] = 0;
      mLastLsu = 1'b0;
      mWen     = 1'b0;
      mAddr    = '0;
      mData    = '0;
    end else begin
      int g;
      bit okIss;
      int net [NR_REG];
      g     = pickGrant();
      okIss = expIssReady();
      for (int i = 0; i < NR_REG; i++) net[i] = 0;
      if (mWen) net[mAddr] -= 1;
      if (bus.i_iss_valid && okIss && bus.i_iss_wen && bus.i_iss_rd != 0) net[bus.i_iss_rd] += 1;
      for (int i = 1; i < NR_REG; i++) begin
        mCnt[i] = mCnt[i] + net[i];
        if (mCnt[i] < 0) mCnt[i] = 0;
        if (mCnt[i] > 3) mCnt[i] = 3;
      end
      if (g == 1) begin
        mWen     = bus.i_exu_wen && bus.i_exu_rd != 0;
        mAddr    = bus.i_exu_rd;
        mData    = bus.i_exu_wdata;
        mLastLsu = 1'b0;
      end else if (g == 2) begin
        mWen     = bus.i_lsu_rd != 0;
        mAddr    = bus.i_lsu_rd;
        mData    = bus.i_lsu_wdata;
        mLastLsu = 1'b1;
      end else begin
        mWen = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model midway through each cycle.
  always @(negedge clk) begin
    #2;
    checkOutput("model rf_wen",    bus.o_rf_wen,    mWen);
    checkOutput("model rf_waddr",  bus.o_rf_waddr,  mAddr);
    checkOutput("model rf_wdata",  bus.o_rf_wdata,  mData);
    checkOutput("model busy",      bus.o_busy,      expBusy());
    checkOutput("model hazard",    bus.o_hazard,    expHazard());
    checkOutput("model iss_ready", bus.o_iss_ready, expIssReady());
    checkOutput("model exu_ready", bus.o_exu_ready, pickGrant() == 1);
    checkOutput("model lsu_ready", bus.o_lsu_ready, pickGrant() == 2);
  end

  task automatic applyStimulus(
    input logic issV, input logic issW, input logic [AW-1:0] issRd,
    input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
    input logic exuV, input logic exuW, input logic [AW-1:0] exuRd, input logic [XLEN-1:0] exuD,
    input logic lsuV, input logic [AW-1:0] lsuRd, input logic [XLEN-1:0] lsuD);
    bus.i_iss_valid = issV;
    bus.i_iss_wen   = issW;
    bus.i_iss_rd    = issRd;
    bus.i_chk_rs1   = rs1;
    bus.i_chk_rs2   = rs2;
    bus.i_exu_valid = exuV;
    bus.i_exu_wen   = exuW;
    bus.i_exu_rd    = exuRd;
    bus.i_exu_wdata = exuD;
    bus.i_lsu_valid = lsuV;
    bus.i_lsu_rd    = lsuRd;
    bus.i_lsu_wdata = lsuD;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset rf_wen",    bus.o_rf_wen,    0);
    checkOutput("reset busy",      bus.o_busy,      0);
    checkOutput("reset hazard",    bus.o_hazard,    0);
    checkOutput("reset iss_ready", bus.o_iss_ready, 1);
    step(); step();
    rst_n = 1'b1;

    // Single EXU write to x5.
    applyStimulus(1, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("exu1 hazard before issue", bus.o_hazard, 0);
    step();
    applyStimulus(0, 0, 0, 5, 0, 1, 1, 5, 'h1234, 0, 0, 0);
    #3 checkOutput("exu1 hazard pending", bus.o_hazard, 1);
    checkOutput("exu1 exu_ready", bus.o_exu_ready, 1);
    step();
    applyStimulus(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("exu1 rf_wen", bus.o_rf_wen, 1);
    checkOutput("exu1 rf_waddr", bus.o_rf_waddr, 5);
    checkOutput("exu1 rf_wdata", bus.o_rf_wdata, 'h1234);
    checkOutput("exu1 hazard during write", bus.o_hazard, 1);
    step();
    #3 checkOutput("exu1 hazard cleared", bus.o_hazard, 0);
    checkOutput("exu1 rf_wen low", bus.o_rf_wen, 0);

    // Contention right after reset: LSU, EXU, LSU, EXU.
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 3, 0, 0, 1, 1, 1, 'h100 + k, 1, 2, 'h200 + k);
      #3 checkOutput("contend lsu_ready", bus.o_lsu_ready, (k % 2) == 0);
      checkOutput("contend exu_ready", bus.o_exu_ready, (k % 2) == 1);
      if (k > 0) checkOutput("contend rf_waddr", bus.o_rf_waddr, (k % 2) == 1 ? 2 : 1);
      step();
    end
    applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("contend last rf_waddr", bus.o_rf_waddr, 1);
    checkOutput("contend busy", bus.o_busy, 1);
    checkOutput("contend iss_ready full", bus.o_iss_ready, 0);
    rst_n = 1'b0;
    #1 checkOutput("midreset rf_wen", bus.o_rf_wen, 0);
    checkOutput("midreset busy", bus.o_busy, 0);
    checkOutput("midreset iss_ready", bus.o_iss_ready, 1);
    step(); step();
    rst_n = 1'b1;

    // Saturation on x3.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    applyStimulus(1, 1, 3, 0, 0, 1, 1, 3, 'h33, 0, 0, 0);
    #3 checkOutput("sat iss_ready full", bus.o_iss_ready, 0);
    checkOutput("sat exu_ready", bus.o_exu_ready, 1);
    step();
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("sat commit wen", bus.o_rf_wen, 1);
    checkOutput("sat still full", bus.o_iss_ready, 0);
    step();
    applyStimulus(0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("sat iss_ready freed", bus.o_iss_ready, 1);
    checkOutput("sat hazard", bus.o_hazard, 1);
    step();

    // Issue and commit to x7 in the same cycle.
    applyStimulus(1, 1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 7, 0, 1, 1, 7, 'h77, 0, 0, 0);
    #3 checkOutput("same hazard before", bus.o_hazard, 1);
    step();
    applyStimulus(1, 1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("same rf_waddr", bus.o_rf_waddr, 7);
    checkOutput("same rf_wen", bus.o_rf_wen, 1);
    step();
    applyStimulus(0, 0, 0, 7, 0, 1, 1, 7, 'h78, 0, 0, 0);
    #3 checkOutput("same hazard held", bus.o_hazard, 1);
    step();
    applyStimulus(0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    #3 checkOutput("same hazard after one commit", bus.o_hazard, 0);

    // LSU write to x0.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hdead);
    #3 checkOutput("x0 lsu_ready", bus.o_lsu_ready, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("x0 rf_wen", bus.o_rf_wen, 0);
    checkOutput("x0 busy unchanged", bus.o_busy, 1);
    step();

    // Random traffic with one reset pulse in the middle.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 50, $urandom_range(0, 9) < 8, AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    $urandom_range(0, 99) < 45, $urandom_range(0, 9) < 8, AW'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 99) < 45, AW'($urandom_range(0, 7)), $urandom);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060124_wb_arbiter.md
# ysyx_23060124_wb_arbiter

Shares the single GPR write port between the EXU result path and the LSU load-return path, and keeps a per-register scoreboard of in-flight destination writes. Sits between the EXU/LSU writeback outputs and the register file. Gives the IDU an issue-side hazard signal so dependent instructions stall until their source operands are written.

## Interface

**Parameters**
- `XLEN`, default 32: data width.
- `NR_REG`, default 16: number of GPRs (RV32E).
- `AW`, default 4: register index width, log2(`NR_REG`).

**Ports**
- `clk`, in, 1: clock, rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_iss_valid`, in, 1: IDU issues an instruction this cycle.
- `i_iss_wen`, in, 1: issued instruction writes a GPR.
- `i_iss_rd`, in, `AW`: destination register of the issued instruction.
- `o_iss_ready`, out, 1: issue accepted (scoreboard not saturated for `i_iss_rd`).
- `i_chk_rs1`, in, `AW`: source register index to check.
- `i_chk_rs2`, in, `AW`: source register index to check.
- `o_hazard`, out, 1: rs1 or rs2 has a pending write.
- `i_exu_valid`, in, 1: EXU writeback request.
- `o_exu_ready`, out, 1: EXU request granted.
- `i_exu_wen`, in, 1: EXU request writes a GPR.
- `i_exu_rd`, in, `AW`: EXU destination register.
- `i_exu_wdata`, in, `XLEN`: EXU write data (pc+4 already selected for jal/jalr).
- `i_lsu_valid`, in, 1: LSU load-return request (always a write).
- `o_lsu_ready`, out, 1: LSU request granted.
- `i_lsu_rd`, in, `AW`: LSU destination register.
- `i_lsu_wdata`, in, `XLEN`: LSU write data.
- `o_rf_wen`, out, 1: register-file write enable (registered).
- `o_rf_waddr`, out, `AW`: register-file write address (registered).
- `o_rf_wdata`, out, `XLEN`: register-file write data (registered).
- `o_busy`, out, 1: any scoreboard counter is nonzero.

## Operation

**Scoreboard**
- One 2-bit counter per register; x0 is never tracked.
- Issue increments `cnt[i_iss_rd]` on `i_iss_valid && o_iss_ready && i_iss_wen && rd!=0`.
- `o_iss_ready = !(i_iss_wen && rd!=0 && cnt[rd]==3)`.
- Commit decrements `cnt[o_rf_waddr]` in any cycle where `o_rf_wen` is high.
- Increment and decrement of the same register in one cycle leave the counter unchanged.
- `o_hazard = (rs1!=0 && cnt[rs1]!=0) || (rs2!=0 && cnt[rs2]!=0)`. Combinational.

**Arbitration**
- Two requesters; round-robin pointer `last` (0 = EXU, 1 = LSU).
- Only one valid: grant it.
- Both valid: grant the side not equal to `last`.
- `last` updates to the granted side on every grant.
- Grant is `ready` for the same cycle; the output stage never back-pressures, since the register file always accepts.
- Ready may depend on both valids. A requester must not make its valid depend on its ready.

**Write port**
- On grant, capture `{wen, rd, wdata}` into the output register.
- EXU `wen` = `i_exu_wen`; LSU `wen` = 1.
- If rd==0, `o_rf_wen` is forced 0 and no counter moves.
- EXU requests with `i_exu_wen`=0 are still granted and consume a slot, with no write.

## Timing

- Reset, asynchronous: `o_rf_wen`=0, `o_rf_waddr`=0, `o_rf_wdata`=0, all counters 0, `last`=0 (LSU wins the first contest).
- Reset values of the combinational outputs under reset: `o_busy`=0, `o_hazard`=0, `o_iss_ready`=1.
- Accept at edge N (valid && ready in cycle N-1): `o_rf_*` are valid during cycle N.
- The register file writes, and the counter decrements, at edge N+1.
- `o_hazard` for that register drops in cycle N+1 and the register file holds the new data in the same cycle. No bypass.
- Back-to-back grants every cycle are supported: throughput is 1 write/cycle.
- A reset asserted mid-operation discards the output register and all counters. Upstream is reset together with this block.

## Structure

- Shared package: `XLEN`, `NR_REG`, `AW`, and a `wb_req_t` struct `{wen, rd, wdata}`.
- One sub-module is natural: `ysyx_23060124_sb_cnt`, a single 2-bit saturating up/down counter instantiated `NR_REG`-1 times.
- Arbiter and output register are inline.

## Test plan

- **Reset:** assert `i_rst_n`=0 mid-traffic → `o_rf_wen`=0, `o_busy`=0, `o_iss_ready`=1 immediately, without waiting for a clock edge.
- **Single EXU write:** issue rd=5; `i_chk_rs1`=5 → `o_hazard`=1.
  - EXU valid rd=5, wdata=0x1234 → `o_exu_ready`=1.
  - Next cycle `o_rf_wen`=1, waddr=5, wdata=0x1234.
  - The cycle after that, `o_hazard`=0.
- **Contention:** EXU and LSU both valid for 4 cycles after reset → grants LSU, EXU, LSU, EXU; `o_rf_waddr` follows the same order one cycle later.
- **Saturation:** issue rd=3 three times with no commit → fourth issue sees `o_iss_ready`=0; one commit to rd=3 → `o_iss_ready`=1.
- **Same-cycle issue and commit:** issue rd=7 in the cycle `o_rf_wen` is high for rd=7 with `cnt`=1 → `cnt` stays 1 and `o_hazard` stays 1.
- **x0:** LSU write to rd=0 → granted, `o_rf_wen`=0, no counter changes.
